// File: rtl/moving_avg_filter_pkg.sv
// ---------------------------------------------------------------------------
// moving_avg_filter_pkg
// Shared definitions for the moving-average filter slice.
//   state_t    : filter mode (BYPASS, FILL, RUN)
//   SUM_W      : accumulator width for the default parameter set
//   sum_width(): accumulator width for any (DATA_W, LOG2_N) pair; the sum
//                of N samples of DATA_W bits always fits in DATA_W+LOG2_N.
// ---------------------------------------------------------------------------
package moving_avg_filter_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LOG2_N = 3;
    localparam int SUM_W          = DEFAULT_DATA_W + DEFAULT_LOG2_N;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2
    } state_t;

    function automatic int sum_width(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/moving_avg_filter_ring.sv
// ---------------------------------------------------------------------------
// moving_avg_filter_ring (avg_ring_buffer)
// Sample history for the boxcar window: 2^LOG2_N x DATA_W registers.
// Ports:
//   clk, sys_rst_n : clock, async active-low reset (pointer only)
//   we             : write wdata at wr_ptr and advance the pointer
//   clr            : return the pointer to slot 0 (window restart)
//   wdata          : sample to store
//   rd_data        : combinational read of mem[wr_ptr], i.e. the oldest
//                    sample once the window is full
//   wr_ptr         : current write pointer
// Buffer contents are not reset; the filter never reads a slot before it
// has been written since the last restart.
// ---------------------------------------------------------------------------
module moving_avg_filter_ring #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              we,
    input  logic              clr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [LOG2_N-1:0] wr_ptr
);

    localparam int N = 1 << LOG2_N;

    logic [DATA_W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer wraps N-1 -> 0 through natural LOG2_N-bit overflow.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
        end else if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/moving_avg_filter.sv
// ---------------------------------------------------------------------------
// moving_avg_filter
// Streaming boxcar filter behind the UART command parser (clk_ref domain).
// With filter_enable=1 it outputs the floor average of the last 2^LOG2_N
// samples; during warm-up and with filter_enable=0 samples pass through.
// Ports:
//   clk           : 96 MHz clk_ref
//   sys_rst_n     : asynchronous active-low reset
//   filter_enable : 1 = average, 0 = bypass (level, same clock domain)
//   din_valid/din : sample strobe and sample
//   dout_valid    : din_valid delayed by exactly one cycle
//   dout          : filtered or bypassed sample, held between strobes
//   filter_active : registered, 1 while the FSM is in RUN
// Handshake: din_valid is a one-cycle qualifier per sample, no ready
// signal, no backpressure; every accepted sample yields one dout_valid
// pulse on the following cycle.
// ---------------------------------------------------------------------------
module moving_avg_filter
    import moving_avg_filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              filter_enable,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout,
    output logic              filter_active
);

    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = sum_width(DATA_W, LOG2_N);
    localparam logic [LOG2_N:0] LAST_FILL = (LOG2_N + 1)'(N - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ACC_W-1:0]  sum_q;
    logic [LOG2_N:0]   fill_cnt_q;
    logic [LOG2_N-1:0] wr_ptr;
    logic [DATA_W-1:0] oldest;

    logic              filling;
    logic              window_done;
    logic              buf_we;
    logic              buf_clr;
    logic [ACC_W-1:0]  sum_add;
    logic [ACC_W-1:0]  sum_run;

    moving_avg_filter_ring #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .we        (buf_we),
        .clr       (buf_clr),
        .wdata     (din),
        .rd_data   (oldest),
        .wr_ptr    (wr_ptr)
    );

    // Datapath helpers. sum_run adds before subtracting; any transient
    // overflow of sum+din cancels because the final value always fits.
    always_comb begin
        sum_add     = sum_q + ACC_W'(din);
        sum_run     = sum_add - ACC_W'(oldest);
        // A sample taken with enable high in BYPASS is the first FILL sample.
        filling     = filter_enable && (state_q != RUN);
        window_done = filling && din_valid && (fill_cnt_q == LAST_FILL);
        buf_we      = filter_enable && din_valid;
        buf_clr     = !filter_enable;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= BYPASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!filter_enable) begin
            state_d = BYPASS;
        end else begin
            case (state_q)
                BYPASS:  state_d = window_done ? RUN : FILL;
                FILL:    if (window_done) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = BYPASS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sum_q         <= '0;
            fill_cnt_q    <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            filter_active <= 1'b0;
        end else begin
            dout_valid    <= din_valid;
            filter_active <= (state_d == RUN);
            if (!filter_enable) begin
                // Disabling discards all history so a later enable starts empty.
                sum_q      <= '0;
                fill_cnt_q <= '0;
                if (din_valid) begin
                    dout <= din;
                end
            end else if (din_valid) begin
                if (state_q == RUN) begin
                    sum_q <= sum_run;
                    dout  <= DATA_W'(sum_run >> LOG2_N);
                end else begin
                    sum_q      <= sum_add;
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                    // Warm-up passes samples through; no partial averages.
                    dout       <= window_done ? DATA_W'(sum_add >> LOG2_N) : din;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_avg_filter.sv
module tb_moving_avg_filter;

    localparam int DATA_W = 8;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic              clk;
    logic              sys_rst_n;
    logic              filter_enable;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              dout_valid;
    logic [DATA_W-1:0] dout;
    logic              filter_active;

    int n_checks;
    int n_fail;

    moving_avg_filter #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) dut (
        .clk           (clk),
        .sys_rst_n     (sys_rst_n),
        .filter_enable (filter_enable),
        .din_valid     (din_valid),
        .din           (din),
        .dout_valid    (dout_valid),
        .dout          (dout),
        .filter_active (filter_active)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // The window is just the list of samples accepted since the last
    // enable/reset; the average exists once it holds N samples.
    int                m_hist[$];
    logic [DATA_W-1:0] m_dout;
    logic              m_valid;
    logic              m_active;

    task automatic model_reset();
        m_hist.delete();
        m_dout   = '0;
        m_valid  = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic v, input logic [DATA_W-1:0] d);
        int s;
        m_valid = v;
        if (!en) begin
            m_hist.delete();
            if (v) m_dout = d;
        end else if (v) begin
            m_hist.push_back(int'(d));
            if (m_hist.size() > N) void'(m_hist.pop_front());
            if (m_hist.size() == N) begin
                s = 0;
                foreach (m_hist[i]) s += m_hist[i];
                m_dout = DATA_W'(s / N);
            end else begin
                m_dout = d;
            end
        end
        m_active = en && (m_hist.size() == N);
    endtask

    // ---------------- checker ----------------
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic en, input logic v, input logic [DATA_W-1:0] d);
        @(negedge clk);
        filter_enable = en;
        din_valid     = v;
        din           = d;
        @(posedge clk);
        #1;
        model_step(en, v, d);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},  int'(dout_valid),    int'(m_valid));
        check({tag, ".dout"},   int'(dout),          int'(m_dout));
        check({tag, ".active"}, int'(filter_active), int'(m_active));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic              en;
        logic              v;
        logic [DATA_W-1:0] d;
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic              ea;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic v, input logic [DATA_W-1:0] d,
                       input logic ev, input logic [DATA_W-1:0] ed, input logic ea);
        vec_t t;
        t.en = en; t.v = v; t.d = d; t.ev = ev; t.ed = ed; t.ea = ea;
        tbl.push_back(t);
    endtask

    task automatic add_idle(input logic en, input int cnt, input logic [DATA_W-1:0] held,
                            input logic ea);
        for (int i = 0; i < cnt; i++) add(en, 1'b0, 8'd0, 1'b0, held, ea);
    endtask

    task automatic build_table();
        // Bypass
        add(0, 1, 10, 1, 10, 0);
        add(0, 1, 20, 1, 20, 0);
        add(0, 1, 30, 1, 30, 0);
        // Fill then run
        add(1, 1, 4,  1, 4,  0);
        add(1, 1, 8,  1, 8,  0);
        add(1, 1, 12, 1, 12, 0);
        add(1, 1, 16, 1, 10, 1);
        add(1, 1, 20, 1, 14, 1);
        add(1, 1, 24, 1, 18, 1);
        add_idle(0, 1, 18, 0);
        // Truncation with idle gaps: 1+2+2+2 = 7 -> 1
        add(1, 1, 1, 1, 1, 0);
        add_idle(1, 3, 1, 0);
        add(1, 1, 2, 1, 2, 0);
        add_idle(1, 3, 2, 0);
        add(1, 1, 2, 1, 2, 0);
        add_idle(1, 3, 2, 0);
        add(1, 1, 2, 1, 1, 1);
        add_idle(1, 1, 1, 1);
        // Push 100 x4 through the running window
        add(1, 1, 100, 1, 26,  1);
        add(1, 1, 100, 1, 51,  1);
        add(1, 1, 100, 1, 75,  1);
        add(1, 1, 100, 1, 100, 1);
        // Disable with a sample in the same cycle, then restart from empty
        add(0, 1, 50, 1, 50, 0);
        add(1, 1, 0,  1, 0,  0);
        add(1, 1, 0,  1, 0,  0);
        add(1, 1, 0,  1, 0,  0);
        add(1, 1, 0,  1, 0,  1);
        // Full scale and pointer wrap
        add_idle(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 1, 255, 1, 255, (i >= N - 1) ? 1'b1 : 1'b0);
        add(1, 1, 0, 1, 191, 1);
        add(1, 1, 0, 1, 127, 1);
        add(1, 1, 0, 1, 63,  1);
        add(1, 1, 0, 1, 0,   1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        sys_rst_n     = 1'b0;
        filter_enable = 1'b0;
        din_valid     = 1'b0;
        din           = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset.valid",  int'(dout_valid),    0);
        check("reset.dout",   int'(dout),          0);
        check("reset.active", int'(filter_active), 0);
        @(negedge clk);
        sys_rst_n = 1'b1;

        // Table-driven directed vectors
        build_table();
        foreach (tbl[k]) begin
            drive(tbl[k].en, tbl[k].v, tbl[k].d);
            check($sformatf("vec%0d.valid", k),  int'(dout_valid),    int'(tbl[k].ev));
            check($sformatf("vec%0d.dout", k),   int'(dout),          int'(tbl[k].ed));
            check($sformatf("vec%0d.active", k), int'(filter_active), int'(tbl[k].ea));
        end

        // Enable toggles 1->0->1 with no sample in between: window restarts
        drive(1, 1, 200);
        drive(1, 1, 200);
        drive(0, 0, 0);
        check_model("toggle.off");
        drive(1, 1, 8);
        check("toggle.first.dout", int'(dout), 8);
        drive(1, 1, 8);
        drive(1, 1, 8);
        check("toggle.active3", int'(filter_active), 0);
        drive(1, 1, 4);
        check("toggle.avg", int'(dout), 7);
        check("toggle.active4", int'(filter_active), 1);

        // Randomized stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 11) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  DATA_W'($urandom_range(0, 255)));
            check_model($sformatf("rand%0d", i));
        end

        // Asynchronous reset in mid-stream
        drive(0, 1, 77);
        check("prerst.dout", int'(dout), 77);
        @(negedge clk);
        filter_enable = 1'b1;
        din_valid     = 1'b1;
        din           = 8'd5;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_rst.valid",  int'(dout_valid),    0);
        check("async_rst.dout",   int'(dout),          0);
        check("async_rst.active", int'(filter_active), 0);
        @(posedge clk);
        #1;
        check("held_rst.valid", int'(dout_valid), 0);
        @(negedge clk);
        din_valid = 1'b0;
        sys_rst_n = 1'b1;
        model_reset();
        drive(1, 1, 4);
        check("postrst.s1", int'(dout), 4);
        drive(1, 1, 8);
        check("postrst.s2", int'(dout), 8);
        drive(1, 1, 12);
        check("postrst.s3", int'(dout), 12);
        drive(1, 1, 16);
        check("postrst.s4", int'(dout), 10);
        check_model("postrst");
        drive(1, 0, 0);
        check("postrst.novalid", int'(dout_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
